atm_transaction_ctrl: RTL and testbench
=======================================

ATM_TRANSACTION_CTRL -- requirements
Module: atm_transaction_ctrl

Interface
REQ-001 Parameter balance_width, default 20, width of balance, amount and updated_balance.
REQ-002 Parameter max_attempts, default 3, wrong-password attempts before lock.
REQ-003 Parameter timeout_cycles, default 1000, idle cycles in MENU before session abort.
REQ-004 Parameter withdraw_limit, default 20000, maximum single withdrawal amount.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 card_in  input  1  card present; shared with card-handling block.
REQ-008 wrong_psw  input  1  registered password-check result from card-handling block.
REQ-009 balance  input  balance_width  current account balance from card-handling block.
REQ-010 op_valid  input  1  user operation request.
REQ-011 op_code  input  2  00 inquiry, 01 withdraw, 10 deposit, 11 exit.
REQ-012 amount  input  balance_width  operation amount.
REQ-013 op_ready  output  1  high only in MENU; request accepted when op_valid && op_ready.
REQ-014 op_done  output  1  one-cycle commit strobe to card-handling block.
REQ-015 updated_balance  output  balance_width  new balance, valid while op_done high.
REQ-016 balance_out  output  balance_width  displayed balance.
REQ-017 err_code  output  3  0 none, 1 insufficient, 2 overflow, 3 over-limit, 4 timeout, 5 bad password.
REQ-018 locked  output  1  card locked for the current insertion.

Function
REQ-019 FSM states SHALL be IDLE, AUTH, MENU, EXEC, COMMIT, LOCKED.
REQ-020 IDLE -> AUTH on card_in rising; AUTH samples wrong_psw on the second cycle after entry, allowing one cycle of card-handling latency.
REQ-021 AUTH, wrong_psw low: clear attempt counter and go to MENU.
REQ-022 AUTH, wrong_psw high: increment attempt counter, err_code=5 for one cycle, then re-sample after one more cycle; when count reaches max_attempts go to LOCKED.
REQ-023 LOCKED: locked=1, op_ready=0; exit to IDLE only on card_in low; attempt counter clears on that exit.
REQ-024 MENU: op_ready=1; accepted request registers op_code and amount and moves to EXEC next cycle.
REQ-025 EXEC inquiry: balance_out=balance, return to MENU, no op_done.
REQ-026 EXEC withdraw: amount>withdraw_limit -> err_code=3; amount>balance -> err_code=1; otherwise new balance = balance-amount; limit check has priority.
REQ-027 EXEC deposit: sum computed at balance_width+1 bits; carry set -> err_code=2, no commit; otherwise new balance = sum.
REQ-028 Errors: err_code SHALL be held one cycle, return to MENU, op_done stays low.
REQ-029 COMMIT: op_done=1 exactly one cycle, updated_balance and balance_out = new balance, then MENU.
REQ-030 Exit (11): return to IDLE, no op_done.
REQ-031 card_in low in any state except IDLE: go to IDLE next cycle, no op_done; card removal in EXEC or COMMIT SHALL suppress a not-yet-issued op_done.
REQ-032 MENU idle counter counts cycles without accepted request; at timeout_cycles go to IDLE with err_code=4 for one cycle; counter clears on any accepted request or MENU exit.
REQ-033 Amount 0 withdraw/deposit SHALL commit with unchanged balance.

Reset
REQ-034 rst high SHALL immediately force IDLE and zero all outputs, counters and registered operands, including mid-EXEC/COMMIT (no op_done).
REQ-035 After rst deasserts with card_in already high, FSM SHALL wait for card_in low then high before entering AUTH.

Structure
REQ-036 Shared package atm_pkg SHALL hold the state enum, op_code constants and err_code constants.
REQ-037 One sub-module atm_timeout_counter (load/clear, enable, expire pulse) SHALL implement the MENU timeout.

Verification
REQ-038 balance=500, correct password, withdraw 200 -> op_done one cycle, updated_balance=300, err_code=0.
REQ-039 balance=500, withdraw 600 -> err_code=1 for one cycle, op_done never high, state MENU.
REQ-040 balance=1048575, deposit 1 -> err_code=2, no op_done; deposit 0 -> op_done, updated_balance=1048575.
REQ-041 Three consecutive wrong_psw=1 samples -> locked=1, op_ready=0 until card_in low, then IDLE, locked=0.
REQ-042 timeout_cycles=8, no op_valid in MENU -> IDLE after 8 cycles, err_code=4 one cycle.
REQ-043 rst pulse during EXEC of withdraw 100 -> all outputs 0 immediately, op_done never asserted.

Source files
------------

// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM transaction controller:
//   - state_t   : controller FSM state encoding
//   - OP_*      : user operation codes carried on op_code
//   - ERR_*     : error codes reported on err_code
// -----------------------------------------------------------------------------
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AUTH   = 3'd1,
    ST_MENU   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  localparam logic [1:0] OP_INQUIRY  = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_EXIT     = 2'b11;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_INSUFFICIENT = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW     = 3'd2;
  localparam logic [2:0] ERR_OVER_LIMIT   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT      = 3'd4;
  localparam logic [2:0] ERR_BAD_PSW      = 3'd5;

endpackage

// File: rtl/atm_timeout_counter.sv
// -----------------------------------------------------------------------------
// atm_timeout_counter
// Counts enabled cycles and raises expire during the limit-th consecutive
// enabled cycle, so the owner can act on the same clock edge.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear of the count (wins over enable)
//   enable    : count this cycle
//   expire    : combinational pulse, high in the limit-th enabled cycle
// -----------------------------------------------------------------------------
module atm_timeout_counter #(
  parameter int limit = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int cnt_width = (limit > 1) ? $clog2(limit + 1) : 1;
  localparam logic [cnt_width-1:0] last_count = cnt_width'(limit - 1);

  logic [cnt_width-1:0] count;

  assign expire = enable && !clear && (count == last_count);

  // Idle-cycle count; wraps to zero on expiry so a stale count never lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == last_count) begin
        count <= '0;
      end else begin
        count <= count + cnt_width'(1'b1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/atm_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// atm_transaction_ctrl
// Session controller for one card insertion: password check with attempt
// lockout, operation menu with idle timeout, balance arithmetic and a
// one-cycle commit strobe towards the card-handling block.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   card_in          : card present
//   wrong_psw        : registered password-check result (1 = wrong)
//   balance          : current account balance
//   op_valid/op_code : operation request (00 inquiry, 01 withdraw,
//                      10 deposit, 11 exit), accepted with op_ready
//   amount           : operation amount
//   op_ready         : high only while in MENU
//   op_done          : one-cycle commit strobe
//   updated_balance  : new balance, valid while op_done is high
//   balance_out      : displayed balance
//   err_code         : one-cycle error report (see atm_pkg ERR_*)
//   locked           : card locked for this insertion
// -----------------------------------------------------------------------------
module atm_transaction_ctrl
  import atm_pkg::*;
#(
  parameter int balance_width  = 20,
  parameter int max_attempts   = 3,
  parameter int timeout_cycles = 1000,
  parameter int withdraw_limit = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic                     op_ready,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic [balance_width-1:0] balance_out,
  output logic [2:0]               err_code,
  output logic                     locked
);

  localparam int att_width = (max_attempts > 1) ? $clog2(max_attempts + 1) : 1;
  localparam logic [att_width-1:0]     last_attempt = att_width'(max_attempts - 1);
  localparam logic [balance_width-1:0] limit_amount = balance_width'(withdraw_limit);

  state_t                   state;
  logic                     card_q;      // previous card_in, for insertion edge
  logic                     auth_phase;  // 0: latency cycle, 1: sample cycle
  logic [att_width-1:0]     attempts;
  logic [1:0]               op_reg;
  logic [balance_width-1:0] amt_reg;
  logic [balance_width-1:0] new_bal;

  logic                     accept;
  logic                     timer_clear;
  logic                     timer_enable;
  logic                     timer_expire;
  logic [balance_width:0]   deposit_sum;

  assign accept       = (state == ST_MENU) && op_valid && op_ready;
  assign timer_enable = (state == ST_MENU) && !accept;
  assign timer_clear  = (state != ST_MENU) || accept;
  // One extra bit so a deposit that wraps is seen as a carry, not a small sum.
  assign deposit_sum  = {1'b0, balance} + {1'b0, amt_reg};

  atm_timeout_counter #(
    .limit (timeout_cycles)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // Session FSM with all outputs registered alongside the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      // Treat the card as already present so a card left in across reset
      // must be removed and reinserted before authentication starts.
      card_q          <= 1'b1;
      auth_phase      <= 1'b0;
      attempts        <= '0;
      op_reg          <= 2'b00;
      amt_reg         <= '0;
      new_bal         <= '0;
      op_ready        <= 1'b0;
      op_done         <= 1'b0;
      updated_balance <= '0;
      balance_out     <= '0;
      err_code        <= ERR_NONE;
      locked          <= 1'b0;
    end else begin
      card_q   <= card_in;
      op_ready <= 1'b0;
      op_done  <= 1'b0;
      err_code <= ERR_NONE;
      locked   <= 1'b0;

      case (state)
        ST_IDLE: begin
          attempts   <= '0;
          auth_phase <= 1'b0;
          if (card_in && !card_q) begin
            state <= ST_AUTH;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_AUTH: begin
          if (!card_in) begin
            state <= ST_IDLE;
          end else if (!auth_phase) begin
            auth_phase <= 1'b1;
          end else begin
            auth_phase <= 1'b0;
            if (!wrong_psw) begin
              attempts <= '0;
              state    <= ST_MENU;
              op_ready <= 1'b1;
            end else begin
              err_code <= ERR_BAD_PSW;
              attempts <= attempts + att_width'(1'b1);
              if (attempts == last_attempt) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end else begin
                state <= ST_AUTH;
              end
            end
          end
        end

        ST_LOCKED: begin
          if (!card_in) begin
            state    <= ST_IDLE;
            attempts <= '0;
          end else begin
            locked <= 1'b1;
          end
        end

        ST_MENU: begin
          if (!card_in) begin
            state <= ST_IDLE;
          end else if (accept) begin
            op_reg  <= op_code;
            amt_reg <= amount;
            state   <= ST_EXEC;
          end else if (timer_expire) begin
            state    <= ST_IDLE;
            err_code <= ERR_TIMEOUT;
          end else begin
            op_ready <= 1'b1;
          end
        end

        ST_EXEC: begin
          if (!card_in) begin
            state <= ST_IDLE;
          end else begin
            case (op_reg)
              OP_INQUIRY: begin
                balance_out <= balance;
                state       <= ST_MENU;
                op_ready    <= 1'b1;
              end
              OP_WITHDRAW: begin
                // Limit check outranks the balance check.
                if (amt_reg > limit_amount) begin
                  err_code <= ERR_OVER_LIMIT;
                  state    <= ST_MENU;
                  op_ready <= 1'b1;
                end else if (amt_reg > balance) begin
                  err_code <= ERR_INSUFFICIENT;
                  state    <= ST_MENU;
                  op_ready <= 1'b1;
                end else begin
                  new_bal <= balance - amt_reg;
                  state   <= ST_COMMIT;
                end
              end
              OP_DEPOSIT: begin
                if (deposit_sum[balance_width]) begin
                  err_code <= ERR_OVERFLOW;
                  state    <= ST_MENU;
                  op_ready <= 1'b1;
                end else begin
                  new_bal <= deposit_sum[balance_width-1:0];
                  state   <= ST_COMMIT;
                end
              end
              OP_EXIT: begin
                state <= ST_IDLE;
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end

        // The strobe is launched on leaving COMMIT, so pulling the card while
        // in COMMIT still cancels it.
        ST_COMMIT: begin
          if (!card_in) begin
            state <= ST_IDLE;
          end else begin
            op_done         <= 1'b1;
            updated_balance <= new_bal;
            balance_out     <= new_bal;
            state           <= ST_MENU;
            op_ready        <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_transaction_ctrl
// Self-checking bench: directed operation table, multi-cycle corner-case
// sequences (lockout, timeout, card removal, reset mid-operation) and random
// operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_atm_transaction_ctrl;

  localparam int BW       = 20;
  localparam longint MAXB = 1048575;
  localparam longint LIM  = 20000;

  logic          clk;
  logic          rst;
  logic          card_in;
  logic          wrong_psw;
  logic [BW-1:0] balance;
  logic          op_valid;
  logic [1:0]    op_code;
  logic [BW-1:0] amount;
  logic          op_ready;
  logic          op_done;
  logic [BW-1:0] updated_balance;
  logic [BW-1:0] balance_out;
  logic [2:0]    err_code;
  logic          locked;

  int n_checks;
  int n_err;

  typedef struct {
    logic [1:0]    op;
    logic [BW-1:0] amt;
    logic [BW-1:0] bal;
    logic [2:0]    err;
    logic          commit;
    logic [BW-1:0] newbal;
  } vec_t;

  typedef struct {
    logic [2:0]    err;
    logic          commit;
    logic [BW-1:0] newbal;
  } exp_t;

  vec_t vecs[12];

  atm_transaction_ctrl #(
    .balance_width  (BW),
    .max_attempts   (3),
    .timeout_cycles (8),
    .withdraw_limit (20000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .card_in         (card_in),
    .wrong_psw       (wrong_psw),
    .balance         (balance),
    .op_valid        (op_valid),
    .op_code         (op_code),
    .amount          (amount),
    .op_ready        (op_ready),
    .op_done         (op_done),
    .updated_balance (updated_balance),
    .balance_out     (balance_out),
    .err_code        (err_code),
    .locked          (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  function automatic exp_t model(input logic [1:0] op, input longint amt, input longint bal);
    exp_t e;
    e.err = 3'd0; e.commit = 1'b0; e.newbal = '0;
    if (op == 2'b01) begin
      if (amt > LIM) e.err = 3'd3;
      else if (amt > bal) e.err = 3'd1;
      else begin e.commit = 1'b1; e.newbal = BW'(bal - amt); end
    end else if (op == 2'b10) begin
      if (bal + amt > MAXB) e.err = 3'd2;
      else begin e.commit = 1'b1; e.newbal = BW'(bal + amt); end
    end
    return e;
  endfunction

  // Card out, card in with a good password; MENU is reached on the third edge.
  task automatic login();
    card_in = 1'b0; wrong_psw = 1'b0;
    step(); step();
    card_in = 1'b1;
    step(); step();
    check("auth_latency_ready", op_ready, 1'b0);
    step();
    check("login_ready", op_ready, 1'b1);
  endtask

  // Issue one operation from MENU and check every cycle of its outcome.
  task automatic do_op(input string name, input logic [1:0] op, input logic [BW-1:0] amt,
                       input logic [BW-1:0] bal, input logic [2:0] xerr,
                       input logic xcommit, input logic [BW-1:0] xnew);
    op_valid = 1'b1; op_code = op; amount = amt; balance = bal;
    step();
    op_valid = 1'b0;
    check({name, "_exec_ready"}, op_ready, 1'b0);
    step();
    if (op == 2'b11) begin
      check({name, "_exit_ready"}, op_ready, 1'b0);
      check({name, "_exit_done"}, op_done, 1'b0);
    end else if (op == 2'b00) begin
      check({name, "_inq_bal"}, balance_out, bal);
      check({name, "_inq_ready"}, op_ready, 1'b1);
      check({name, "_inq_done"}, op_done, 1'b0);
    end else if (!xcommit) begin
      check({name, "_err"}, err_code, xerr);
      check({name, "_err_done"}, op_done, 1'b0);
      check({name, "_err_ready"}, op_ready, 1'b1);
      step();
      check({name, "_err_clear"}, err_code, 3'd0);
      check({name, "_err_done2"}, op_done, 1'b0);
    end else begin
      check({name, "_commit_err"}, err_code, 3'd0);
      check({name, "_commit_pre"}, op_done, 1'b0);
      step();
      check({name, "_done"}, op_done, 1'b1);
      check({name, "_upd"}, updated_balance, xnew);
      check({name, "_balout"}, balance_out, xnew);
      check({name, "_menu"}, op_ready, 1'b1);
      step();
      check({name, "_done_once"}, op_done, 1'b0);
    end
  endtask

  initial begin
    exp_t e;
    logic [1:0] rop;
    logic [BW-1:0] ramt, rbal;
    logic any_done;

    n_checks = 0; n_err = 0;
    rst = 1'b1; card_in = 1'b0; wrong_psw = 1'b0; balance = '0;
    op_valid = 1'b0; op_code = 2'b00; amount = '0;

    //            op     amt      bal       err   commit newbal
    vecs[0]  = '{2'b01, 20'd200,   20'd500,     3'd0, 1'b1, 20'd300};
    vecs[1]  = '{2'b01, 20'd600,   20'd500,     3'd1, 1'b0, 20'd0};
    vecs[2]  = '{2'b10, 20'd1,     20'd1048575, 3'd2, 1'b0, 20'd0};
    vecs[3]  = '{2'b10, 20'd0,     20'd1048575, 3'd0, 1'b1, 20'd1048575};
    vecs[4]  = '{2'b01, 20'd20001, 20'd100000,  3'd3, 1'b0, 20'd0};
    vecs[5]  = '{2'b01, 20'd20000, 20'd100000,  3'd0, 1'b1, 20'd80000};
    vecs[6]  = '{2'b01, 20'd30000, 20'd10,      3'd3, 1'b0, 20'd0};
    vecs[7]  = '{2'b01, 20'd0,     20'd777,     3'd0, 1'b1, 20'd777};
    vecs[8]  = '{2'b01, 20'd500,   20'd500,     3'd0, 1'b1, 20'd0};
    vecs[9]  = '{2'b10, 20'd1,     20'd1048574, 3'd0, 1'b1, 20'd1048575};
    vecs[10] = '{2'b00, 20'd0,     20'd4242,    3'd0, 1'b0, 20'd0};
    vecs[11] = '{2'b10, 20'd123,   20'd1000,    3'd0, 1'b1, 20'd1123};

    // Reset state
    step(); step();
    check("rst_ready", op_ready, 1'b0);
    check("rst_done", op_done, 1'b0);
    check("rst_err", err_code, 3'd0);
    check("rst_locked", locked, 1'b0);
    check("rst_balout", balance_out, 20'd0);
    check("rst_upd", updated_balance, 20'd0);
    rst = 1'b0;
    step();

    // Directed operation table
    login();
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].bal,
            vecs[i].err, vecs[i].commit, vecs[i].newbal);
    end

    // Exit returns to IDLE and stays there while the card remains inserted
    do_op("exit", 2'b11, 20'd0, 20'd100, 3'd0, 1'b0, 20'd0);
    repeat (4) step();
    check("exit_stays_idle", op_ready, 1'b0);

    // Three wrong passwords lock the card
    card_in = 1'b0; step(); step();
    wrong_psw = 1'b1; card_in = 1'b1;
    step(); step(); step();
    check("wrong1_err", err_code, 3'd5);
    check("wrong1_locked", locked, 1'b0);
    step();
    check("wrong1_err_once", err_code, 3'd0);
    step();
    check("wrong2_err", err_code, 3'd5);
    step(); step();
    check("wrong3_err", err_code, 3'd5);
    check("lock_locked", locked, 1'b1);
    check("lock_ready", op_ready, 1'b0);
    wrong_psw = 1'b0;
    repeat (5) step();
    check("lock_hold", locked, 1'b1);
    check("lock_hold_ready", op_ready, 1'b0);
    card_in = 1'b0;
    step();
    check("unlock_locked", locked, 1'b0);
    check("unlock_ready", op_ready, 1'b0);
    // Attempt counter cleared: one wrong then right must not lock
    wrong_psw = 1'b1; card_in = 1'b1;
    step(); step(); step();
    check("retry_err", err_code, 3'd5);
    check("retry_locked", locked, 1'b0);
    wrong_psw = 1'b0;
    step(); step();
    check("retry_menu", op_ready, 1'b1);
    check("retry_not_locked", locked, 1'b0);

    // Menu timeout after 8 idle cycles
    repeat (7) step();
    check("tmo_still_menu", op_ready, 1'b1);
    check("tmo_no_err_yet", err_code, 3'd0);
    step();
    check("tmo_err", err_code, 3'd4);
    check("tmo_ready", op_ready, 1'b0);
    step();
    check("tmo_err_once", err_code, 3'd0);

    // Card removed during EXEC
    login();
    op_valid = 1'b1; op_code = 2'b01; amount = 20'd100; balance = 20'd500;
    step();
    op_valid = 1'b0; card_in = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); any_done |= op_done; end
    check("pull_exec_done", any_done, 1'b0);
    check("pull_exec_ready", op_ready, 1'b0);

    // Card removed during COMMIT
    login();
    op_valid = 1'b1; op_code = 2'b10; amount = 20'd100; balance = 20'd500;
    step();
    op_valid = 1'b0;
    step();
    card_in = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); any_done |= op_done; end
    check("pull_commit_done", any_done, 1'b0);
    check("pull_commit_ready", op_ready, 1'b0);

    // Reset during EXEC of withdraw 100; card stays in across reset
    login();
    op_valid = 1'b1; op_code = 2'b01; amount = 20'd100; balance = 20'd500;
    step();
    op_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_done", op_done, 1'b0);
    check("mid_rst_ready", op_ready, 1'b0);
    check("mid_rst_err", err_code, 3'd0);
    check("mid_rst_balout", balance_out, 20'd0);
    check("mid_rst_upd", updated_balance, 20'd0);
    check("mid_rst_locked", locked, 1'b0);
    step();
    rst = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); any_done |= op_done | op_ready; end
    check("post_rst_no_auth", any_done, 1'b0);
    login();

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      rop = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
      case ($urandom_range(0, 3))
        0: ramt = BW'($urandom_range(0, 20));
        1: ramt = BW'($urandom_range(19990, 20010));
        2: ramt = BW'($urandom_range(0, 1048575));
        default: ramt = BW'($urandom_range(0, 5000));
      endcase
      if ($urandom_range(0, 2) == 0) rbal = BW'($urandom_range(1040000, 1048575));
      else rbal = BW'($urandom_range(0, 1048575));
      repeat ($urandom_range(0, 5)) step();
      e = model(rop, longint'(ramt), longint'(rbal));
      do_op($sformatf("rnd%0d", i), rop, ramt, rbal, e.err, e.commit, e.newbal);
      if (rop == 2'b11) login();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
